// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the rv32 data-memory stage: access-size codes, MMIO map
// offsets, STATUS bit positions and the load-lane extraction helper.
package rv32_mem_pkg;

  localparam logic [2:0] MC_B  = 3'b000;
  localparam logic [2:0] MC_H  = 3'b001;
  localparam logic [2:0] MC_W  = 3'b010;
  localparam logic [2:0] MC_BU = 3'b100;
  localparam logic [2:0] MC_HU = 3'b101;

  localparam logic [31:0] OFF_TOHOST = 32'h0000_0000;
  localparam logic [31:0] OFF_CYCLE  = 32'h0000_0004;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0008;

  localparam int unsigned ST_MISALIGN = 0;
  localparam int unsigned ST_OOR      = 1;

  // Picks the addressed byte/half out of a RAM word and extends it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  addr_lo,
                                               input logic [2:0]  mc);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (mc)
      MC_B:    res = {{24{b[7]}}, b};
      MC_BU:   res = {24'h0, b};
      MC_H:    res = {{16{h[15]}}, h};
      MC_HU:   res = {16'h0, h};
      MC_W:    res = word;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv32_dmem_ram.sv
// Word-organised data RAM with per-byte write enables and an asynchronous read.
// Contents are deliberately not reset.
module rv32_dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[widx];

endmodule

// File: rtl/rv32_dmem.sv
// Data-memory stage: RAM plus a small MMIO window (tohost mailbox, cycle counter,
// sticky W1C fault status). Loads are combinational, stores land on the rising edge.
module rv32_dmem
  import rv32_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memWE,
  input  logic [2:0]  memcontrol,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] tohost,
  output logic        tohostValid,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] tohost_q, cycle_q;
  logic        tohost_valid_q, misalign_q, oor_q;
  logic        misalign_d, oor_d;

  logic        legal, aligned, is_word;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic        in_ram, hit_tohost, hit_cycle, hit_status;
  logic        acc_ok, ram_we, tohost_wr, status_wr, st_mis, st_oor;
  logic [31:0] ram_rdata, status_rd;

  always_comb begin
    legal     = 1'b1;
    aligned   = 1'b1;
    is_word   = 1'b0;
    be        = 4'b0000;
    wdata_rep = writedata;
    case (memcontrol)
      MC_B, MC_BU: begin
        be        = 4'b0001 << addr[1:0];
        wdata_rep = {4{writedata[7:0]}};
      end
      MC_H, MC_HU: begin
        aligned   = ~addr[0];
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{writedata[15:0]}};
      end
      MC_W: begin
        aligned = (addr[1:0] == 2'b00);
        is_word = 1'b1;
        be      = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  end

  assign in_ram     = (addr[31:AW+2] == '0);
  assign hit_tohost = (addr == MMIO_BASE + OFF_TOHOST);
  assign hit_cycle  = (addr == MMIO_BASE + OFF_CYCLE);
  assign hit_status = (addr == MMIO_BASE + OFF_STATUS);
  assign acc_ok     = legal & aligned;

  // RAM has no reset, so stores must be masked here while reset is held.
  assign ram_we    = memWE & reset & acc_ok & in_ram;
  assign tohost_wr = memWE & acc_ok & is_word & hit_tohost;
  assign status_wr = memWE & acc_ok & is_word & hit_status;
  assign st_mis    = memWE & (~acc_ok | ((hit_tohost | hit_status) & ~is_word));
  assign st_oor    = memWE & acc_ok & ~in_ram & ~hit_tohost & ~hit_status;

  // Set wins over a simultaneous W1C clear.
  assign misalign_d = (misalign_q & ~(status_wr & writedata[ST_MISALIGN])) | st_mis;
  assign oor_d      = (oor_q & ~(status_wr & writedata[ST_OOR])) | st_oor;

  rv32_dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .be   (ram_we ? be : 4'b0000),
    .widx (addr[AW+1:2]),
    .wdata(wdata_rep),
    .rdata(ram_rdata)
  );

  always_comb begin
    status_rd              = '0;
    status_rd[ST_MISALIGN] = misalign_q;
    status_rd[ST_OOR]      = oor_q;
  end

  always_comb begin
    readdata = 32'h0;
    if (acc_ok) begin
      if (in_ram) begin
        readdata = lane_extract(ram_rdata, addr[1:0], memcontrol);
      end else if (is_word) begin
        if (hit_tohost)      readdata = tohost_q;
        else if (hit_cycle)  readdata = cycle_q;
        else if (hit_status) readdata = status_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tohost_q       <= 32'h0;
      tohost_valid_q <= 1'b0;
      cycle_q        <= 32'h0;
      misalign_q     <= 1'b0;
      oor_q          <= 1'b0;
    end else begin
      cycle_q        <= cycle_q + 32'd1;
      tohost_valid_q <= tohost_wr;
      if (tohost_wr) tohost_q <= writedata;
      misalign_q     <= misalign_d;
      oor_q          <= oor_d;
    end
  end

  assign tohost      = tohost_q;
  assign tohostValid = tohost_valid_q;
  assign fault       = misalign_q | oor_q;

endmodule
